// File: rtl/rf_writeback_unit_pkg.sv
// Shared definitions for the register-file writeback stage.
//   DEFAULT_DATA_W : default datapath / register width
//   DEFAULT_REG_AW : default register address width (2**REG_AW registers)
//   res_sel_e      : result source select encoding
package rf_writeback_unit_pkg;

    localparam int unsigned DEFAULT_DATA_W = 16;
    localparam int unsigned DEFAULT_REG_AW = 3;

    typedef enum logic [1:0] {
        SEL_ALU  = 2'd0,
        SEL_MEM  = 2'd1,
        SEL_LINK = 2'd2,
        SEL_IMM  = 2'd3
    } res_sel_e;

endpackage

// File: rtl/rf_writeback_unit_if.sv
// Result bus between the execute/memory stages and the writeback unit.
//   master : result producer (drives valid, destination, select and candidate data)
//   slave  : writeback unit (drives res_ready)
interface rf_writeback_unit_if
    import rf_writeback_unit_pkg::*;
#(
    parameter int unsigned DATA_W = DEFAULT_DATA_W,
    parameter int unsigned REG_AW = DEFAULT_REG_AW
) ();

    logic              res_valid;
    logic              res_ready;
    logic [REG_AW-1:0] res_rd;
    res_sel_e          res_sel;
    logic [DATA_W-1:0] alu_result;
    logic [DATA_W-1:0] mem_data;
    logic [DATA_W-1:0] link_pc;
    logic [DATA_W-1:0] imm;

    modport master (
        output res_valid, res_rd, res_sel, alu_result, mem_data, link_pc, imm,
        input  res_ready
    );

    modport slave (
        input  res_valid, res_rd, res_sel, alu_result, mem_data, link_pc, imm,
        output res_ready
    );

endinterface

// File: rtl/rf_writeback_unit_wb_fifo.sv
// Synchronous FIFO buffering {rd, data} results ahead of the register-file write port.
//   clock, reset : clock, asynchronous active-low reset
//   push, wdata  : write request / data (ignored while full)
//   pop, rdata   : read request (ignored while empty) / head entry
//   full, empty  : registered-pointer status flags
module wb_fifo #(
    parameter int unsigned WIDTH = 19,
    parameter int unsigned DEPTH = 2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int unsigned PtrW = $clog2(DEPTH);

    // One extra pointer bit distinguishes full from empty when the indices match.
    logic [PtrW:0]      wr_ptr_q, rd_ptr_q;
    logic [WIDTH-1:0]   mem_q [DEPTH];
    logic               push_en, pop_en;

    assign full    = (wr_ptr_q[PtrW] != rd_ptr_q[PtrW]) &&
                     (wr_ptr_q[PtrW-1:0] == rd_ptr_q[PtrW-1:0]);
    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign push_en = push && !full;
    assign pop_en  = pop && !empty;
    assign rdata   = mem_q[rd_ptr_q[PtrW-1:0]];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push_en) wr_ptr_q <= wr_ptr_q + (PtrW+1)'(1);
            if (pop_en)  rd_ptr_q <= rd_ptr_q + (PtrW+1)'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (push_en) mem_q[wr_ptr_q[PtrW-1:0]] <= wdata;
    end

endmodule

// File: rtl/rf_writeback_unit.sv
// Writeback stage feeding the register-file write port.
//   clock, reset          : clock, asynchronous active-low reset
//   issue_valid/rd/ready  : destination reservation from issue (WAW stall via issue_ready)
//   chk_rs1/rs2, hazard   : RAW check of the instruction under decode
//   res (slave)           : result bus; source selected by res_sel
//   rf_we/waddr/wdata     : registered register-file write port
//   pending_cnt           : number of busy registers
//   err_orphan            : sticky, a result arrived for a register that was not busy
module rf_writeback_unit
    import rf_writeback_unit_pkg::*;
#(
    parameter int unsigned DATA_W = DEFAULT_DATA_W,
    parameter int unsigned REG_AW = DEFAULT_REG_AW,
    parameter int unsigned DEPTH  = 2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              issue_valid,
    input  logic [REG_AW-1:0] issue_rd,
    output logic              issue_ready,
    input  logic [REG_AW-1:0] chk_rs1,
    input  logic [REG_AW-1:0] chk_rs2,
    output logic              hazard,
    rf_writeback_unit_if.slave res,
    output logic              rf_we,
    output logic [REG_AW-1:0] rf_waddr,
    output logic [DATA_W-1:0] rf_wdata,
    output logic [REG_AW:0]   pending_cnt,
    output logic              err_orphan
);

    localparam int unsigned NumRegs = 2 ** REG_AW;
    localparam int unsigned EntryW  = REG_AW + DATA_W;

    logic [NumRegs-1:0] busy_q, busy_d;
    logic [REG_AW:0]    pending_q, pending_d;
    logic               orphan_q, orphan_d;
    logic               rf_we_q;
    logic [REG_AW-1:0]  rf_waddr_q;
    logic [DATA_W-1:0]  rf_wdata_q;

    logic [DATA_W-1:0]  res_data;
    logic               fifo_full, fifo_empty, fifo_push, fifo_pop;
    logic [EntryW-1:0]  fifo_rdata;
    logic               issue_set, busy_clr;

    // busy_q[0] is held at zero, so r0 is always ready and never a hazard.
    assign issue_ready = !busy_q[issue_rd];
    assign hazard      = busy_q[chk_rs1] || busy_q[chk_rs2];
    assign issue_set   = issue_valid && issue_ready && (issue_rd != '0);

    always_comb begin
        res_data = res.alu_result;
        unique case (res.res_sel)
            SEL_ALU:  res_data = res.alu_result;
            SEL_MEM:  res_data = res.mem_data;
            SEL_LINK: res_data = res.link_pc;
            SEL_IMM:  res_data = res.imm;
        endcase
    end

    assign res.res_ready = !fifo_full;
    // r0 results complete the handshake but are dropped here.
    assign fifo_push     = res.res_valid && !fifo_full && (res.res_rd != '0);
    assign fifo_pop      = !fifo_empty;

    wb_fifo #(
        .WIDTH (EntryW),
        .DEPTH (DEPTH)
    ) u_wb_fifo (
        .clock (clock),
        .reset (reset),
        .push  (fifo_push),
        .wdata ({res.res_rd, res_data}),
        .pop   (fifo_pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // The write presented this cycle lands in the register file at the next edge,
    // which is when its busy bit is released. Orphan writes have nothing to release.
    assign busy_clr = rf_we_q && busy_q[rf_waddr_q];

    always_comb begin
        busy_d = busy_q;
        if (busy_clr)  busy_d[rf_waddr_q] = 1'b0;
        if (issue_set) busy_d[issue_rd]   = 1'b1;
        busy_d[0] = 1'b0;

        pending_d = pending_q;
        if (issue_set && !busy_clr)      pending_d = pending_q + (REG_AW+1)'(1);
        else if (!issue_set && busy_clr) pending_d = pending_q - (REG_AW+1)'(1);

        orphan_d = orphan_q || (fifo_push && !busy_q[res.res_rd]);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            busy_q     <= '0;
            pending_q  <= '0;
            orphan_q   <= 1'b0;
            rf_we_q    <= 1'b0;
            rf_waddr_q <= '0;
            rf_wdata_q <= '0;
        end else begin
            busy_q    <= busy_d;
            pending_q <= pending_d;
            orphan_q  <= orphan_d;
            rf_we_q   <= fifo_pop;
            if (fifo_pop) {rf_waddr_q, rf_wdata_q} <= fifo_rdata;
        end
    end

    assign rf_we       = rf_we_q;
    assign rf_waddr    = rf_waddr_q;
    assign rf_wdata    = rf_wdata_q;
    assign pending_cnt = pending_q;
    assign err_orphan  = orphan_q;

endmodule
